// File: rtl/dcache_tlc_scope_pkg.sv
// Shared types and helpers for the hart-0 dcache TileLink C-channel scope capture.
// Opcodes, the summary record layout and the expected-beat calculation.
package dcache_tlc_scope_pkg;

    localparam logic [2:0] ProbeAck     = 3'd4;
    localparam logic [2:0] ProbeAckData = 3'd5;
    localparam logic [2:0] Release      = 3'd6;
    localparam logic [2:0] ReleaseData  = 3'd7;

    localparam int TRUNC_TIMEOUT = 256;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } scope_state_t;

    typedef struct packed {
        logic [44:0] header;
        logic [7:0]  beats;
        logic [31:0] sig;
        logic [2:0]  flags;
    } tlc_rec_t;

    // Data opcodes carry 4-byte beats; anything larger than 512 bytes is clamped.
    function automatic logic [7:0] beats_for(input logic [2:0] opcode, input logic [3:0] size);
        logic [7:0] n;
        n = 8'd1;
        if (opcode[0] && size > 4'd2) begin
            if (size > 4'd9) n = 8'd128;
            else             n = 8'd1 << (size - 4'd2);
        end
        return n;
    endfunction

endpackage

// File: rtl/dcache_tlc_scope_fifo.sv
// First-word-fall-through record FIFO for the scope capture stage.
// A push while full is refused unless a pop happens in the same cycle.
module dcache_tlc_scope_fifo
    import dcache_tlc_scope_pkg::*;
#(
    parameter int  FIFO_DEPTH = 4,
    parameter type rec_t      = tlc_rec_t
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [$bits(rec_t)-1:0]  pushData,
    input  logic                     pop,
    output logic [$bits(rec_t)-1:0]  headData,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [AW:0] PTR_WRAP = {1'b1, {AW{1'b0}}};

    logic [$bits(rec_t)-1:0] mem [FIFO_DEPTH];
    logic [AW:0] wrPtr;
    logic [AW:0] rdPtr;
    logic        doPush;
    logic        doPop;

    assign empty    = (wrPtr == rdPtr);
    assign full     = ((wrPtr ^ rdPtr) == PTR_WRAP);
    assign doPop    = pop & ~empty;
    assign doPush   = push & (~full | doPop);
    assign headData = mem[rdPtr[AW-1:0]];

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr[AW-1:0]] <= pushData;
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (doPop) rdPtr <= rdPtr + PTR_ONE;
        end
    end

endmodule

// File: rtl/dcache_tlc_scope_capture.sv
// Passive capture of dcache TL-C messages into one summary record per message.
// Never back-pressures the probed channel; overflowing records are counted and dropped.
//
//   state | meaning
//   IDLE  | waiting for the first beat of a message
//   BURST | multi-beat data message open, collecting remaining beats
module dcache_tlc_scope_capture
    import dcache_tlc_scope_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  c_ready,
    input  logic                  c_valid,
    input  logic [2:0]            c_opcode,
    input  logic [2:0]            c_param,
    input  logic [3:0]            c_size,
    input  logic [2:0]            c_source,
    input  logic [31:0]           c_address,
    input  logic [31:0]           c_data,
    input  logic                  c_corrupt,
    output logic                  rec_valid,
    input  logic                  rec_ready,
    output logic [44:0]           rec_header,
    output logic [7:0]            rec_beats,
    output logic [31:0]           rec_sig,
    output logic [2:0]            rec_flags,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic                  busy
);

    localparam logic [7:0] IDLE_LAST = 8'(TRUNC_TIMEOUT - 1);
    localparam logic [DROP_CNT_W-1:0] DROP_ONE = 1;

    scope_state_t stateQ, stateNext;

    logic [44:0] hdrQ, hdrNext;
    logic [7:0]  beatsQ, beatsNext;
    logic [31:0] sigQ, sigNext;
    logic        corruptQ, corruptNext;
    logic        changedQ, changedNext;
    logic [7:0]  remQ, remNext;
    logic [7:0]  idleCnt, idleNext;
    logic [DROP_CNT_W-1:0] dropCount;

    logic        fire;
    logic [44:0] inHdr;
    logic [7:0]  expBeats;
    logic        pushEn;
    logic        truncNow;
    tlc_rec_t    pushRec;
    tlc_rec_t    headRec;
    logic        fifoFull;
    logic        fifoEmpty;
    logic        popEn;

    assign fire     = c_valid & c_ready;
    assign inHdr    = {c_opcode, c_param, c_size, c_source, c_address};
    assign expBeats = beats_for(c_opcode, c_size);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateQ    <= IDLE;
            hdrQ      <= '0;
            beatsQ    <= '0;
            sigQ      <= '0;
            corruptQ  <= 1'b0;
            changedQ  <= 1'b0;
            remQ      <= '0;
            idleCnt   <= '0;
        end else begin
            stateQ    <= stateNext;
            hdrQ      <= hdrNext;
            beatsQ    <= beatsNext;
            sigQ      <= sigNext;
            corruptQ  <= corruptNext;
            changedQ  <= changedNext;
            remQ      <= remNext;
            idleCnt   <= idleNext;
        end
    end

    // The pushed record is built from next-state values so the final beat is included.
    always_comb begin
        stateNext   = stateQ;
        hdrNext     = hdrQ;
        beatsNext   = beatsQ;
        sigNext     = sigQ;
        corruptNext = corruptQ;
        changedNext = changedQ;
        remNext     = remQ;
        idleNext    = idleCnt;
        pushEn      = 1'b0;
        truncNow    = 1'b0;
        unique case (stateQ)
            IDLE: begin
                idleNext = '0;
                if (fire) begin
                    hdrNext     = inHdr;
                    beatsNext   = 8'd1;
                    sigNext     = c_opcode[0] ? c_data : 32'd0;
                    corruptNext = c_corrupt;
                    changedNext = 1'b0;
                    if (expBeats == 8'd1) begin
                        pushEn = 1'b1;
                    end else begin
                        stateNext = BURST;
                        remNext   = expBeats - 8'd1;
                    end
                end
            end
            BURST: begin
                if (fire) begin
                    idleNext    = '0;
                    beatsNext   = beatsQ + 8'd1;
                    sigNext     = sigQ ^ c_data;
                    corruptNext = corruptQ | c_corrupt;
                    changedNext = changedQ | (inHdr != hdrQ);
                    remNext     = remQ - 8'd1;
                    if (remQ == 8'd1) begin
                        pushEn    = 1'b1;
                        stateNext = IDLE;
                    end
                end else if (c_valid) begin
                    idleNext = '0;
                end else if (idleCnt == IDLE_LAST) begin
                    idleNext  = '0;
                    pushEn    = 1'b1;
                    truncNow  = 1'b1;
                    stateNext = IDLE;
                end else begin
                    idleNext = idleCnt + 8'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
        pushRec.header = hdrNext;
        pushRec.beats  = beatsNext;
        pushRec.sig    = sigNext;
        pushRec.flags  = {corruptNext, changedNext, truncNow};
    end

    assign popEn = rec_ready & ~fifoEmpty;

    dcache_tlc_scope_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .rec_t      (tlc_rec_t)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (pushEn),
        .pushData (pushRec),
        .pop      (popEn),
        .headData (headRec),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dropCount <= '0;
        end else if (pushEn && fifoFull && !popEn && dropCount != '1) begin
            dropCount <= dropCount + DROP_ONE;
        end
    end

    assign rec_valid  = ~fifoEmpty;
    assign rec_header = headRec.header;
    assign rec_beats  = headRec.beats;
    assign rec_sig    = headRec.sig;
    assign rec_flags  = headRec.flags;
    assign drop_count = dropCount;
    assign busy       = (stateQ == BURST);

endmodule

// File: tb/tb_dcache_tlc_scope_capture.sv
// Directed bench for the TL-C scope capture stage with an expected-record queue.
module tb_dcache_tlc_scope_capture;
    import dcache_tlc_scope_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        c_ready = 1'b1;
    logic        c_valid = 1'b0;
    logic [2:0]  c_opcode = '0;
    logic [2:0]  c_param = '0;
    logic [3:0]  c_size = '0;
    logic [2:0]  c_source = '0;
    logic [31:0] c_address = '0;
    logic [31:0] c_data = '0;
    logic        c_corrupt = 1'b0;
    logic        rec_valid;
    logic        rec_ready = 1'b0;
    logic [44:0] rec_header;
    logic [7:0]  rec_beats;
    logic [31:0] rec_sig;
    logic [2:0]  rec_flags;
    logic [7:0]  drop_count;
    logic        busy;

    int checks = 0;
    int fails  = 0;
    tlc_rec_t expQ[$];

    dcache_tlc_scope_capture #(.FIFO_DEPTH(4), .DROP_CNT_W(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .c_ready    (c_ready),
        .c_valid    (c_valid),
        .c_opcode   (c_opcode),
        .c_param    (c_param),
        .c_size     (c_size),
        .c_source   (c_source),
        .c_address  (c_address),
        .c_data     (c_data),
        .c_corrupt  (c_corrupt),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_header (rec_header),
        .rec_beats  (rec_beats),
        .rec_sig    (rec_sig),
        .rec_flags  (rec_flags),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [44:0] mkHdr(input logic [2:0] op, input logic [2:0] par,
                                          input logic [3:0] sz, input logic [2:0] src,
                                          input logic [31:0] addr);
        return {op, par, sz, src, addr};
    endfunction

    task automatic setBeat(input logic [2:0] op, input logic [2:0] par, input logic [3:0] sz,
                           input logic [2:0] src, input logic [31:0] addr,
                           input logic [31:0] data, input logic corrupt);
        c_valid   = 1'b1;
        c_ready   = 1'b1;
        c_opcode  = op;
        c_param   = par;
        c_size    = sz;
        c_source  = src;
        c_address = addr;
        c_data    = data;
        c_corrupt = corrupt;
    endtask

    task automatic beat(input logic [2:0] op, input logic [2:0] par, input logic [3:0] sz,
                        input logic [2:0] src, input logic [31:0] addr,
                        input logic [31:0] data, input logic corrupt);
        setBeat(op, par, sz, src, addr, data, corrupt);
        tick();
        c_valid   = 1'b0;
        c_corrupt = 1'b0;
    endtask

    task automatic expectRec(input logic [44:0] hdr, input logic [7:0] beats,
                             input logic [31:0] sig, input logic [2:0] flags);
        tlc_rec_t r;
        r.header = hdr;
        r.beats  = beats;
        r.sig    = sig;
        r.flags  = flags;
        expQ.push_back(r);
    endtask

    task automatic cmpHead(input string tag);
        tlc_rec_t e;
        check({tag, ".queued"}, 64'(expQ.size() > 0), 64'd1);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check({tag, ".header"}, 64'(rec_header), 64'(e.header));
            check({tag, ".beats"},  64'(rec_beats),  64'(e.beats));
            check({tag, ".sig"},    64'(rec_sig),    64'(e.sig));
            check({tag, ".flags"},  64'(rec_flags),  64'(e.flags));
        end
    endtask

    task automatic popCheck(input string tag);
        for (int i = 0; i < 20 && !rec_valid; i++) tick();
        check({tag, ".rec_valid"}, 64'(rec_valid), 64'd1);
        if (rec_valid) begin
            cmpHead(tag);
            rec_ready = 1'b1;
            tick();
            rec_ready = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst.rec_valid", 64'(rec_valid), 64'd0);
        check("rst.header", 64'(rec_header), 64'd0);
        check("rst.beats", 64'(rec_beats), 64'd0);
        check("rst.sig", 64'(rec_sig), 64'd0);
        check("rst.flags", 64'(rec_flags), 64'd0);
        check("rst.drop", 64'(drop_count), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        tick();

        // Single-beat ProbeAck: visible the cycle after the fire, data ignored
        beat(ProbeAck, 3'd0, 4'd6, 3'd2, 32'h8000_0040, 32'hDEAD_BEEF, 1'b0);
        expectRec(mkHdr(ProbeAck, 3'd0, 4'd6, 3'd2, 32'h8000_0040), 8'd1, 32'd0, 3'b000);
        check("pa.valid_next_cycle", 64'(rec_valid), 64'd1);
        check("pa.busy", 64'(busy), 64'd0);
        popCheck("pa");
        check("pa.drained", 64'(rec_valid), 64'd0);

        // ReleaseData size 4 with idle gaps and ready-low cycles
        beat(ReleaseData, 3'd1, 4'd4, 3'd3, 32'h0000_1000, 32'h11, 1'b0);
        check("rd4.busy_first", 64'(busy), 64'd1);
        tick();
        setBeat(ReleaseData, 3'd1, 4'd4, 3'd3, 32'h0000_1000, 32'h22, 1'b0);
        c_ready = 1'b0;
        tick();
        tick();
        c_valid = 1'b0;
        c_ready = 1'b1;
        check("rd4.busy_stall", 64'(busy), 64'd1);
        beat(ReleaseData, 3'd1, 4'd4, 3'd3, 32'h0000_1000, 32'h22, 1'b0);
        tick();
        beat(ReleaseData, 3'd1, 4'd4, 3'd3, 32'h0000_1000, 32'h33, 1'b0);
        check("rd4.no_early_rec", 64'(rec_valid), 64'd0);
        beat(ReleaseData, 3'd1, 4'd4, 3'd3, 32'h0000_1000, 32'h44, 1'b0);
        expectRec(mkHdr(ReleaseData, 3'd1, 4'd4, 3'd3, 32'h0000_1000), 8'd4, 32'h44, 3'b000);
        check("rd4.busy_after", 64'(busy), 64'd0);
        check("rd4.valid", 64'(rec_valid), 64'd1);
        popCheck("rd4");

        // Header change and corrupt on beat 2; latched header retained
        beat(ReleaseData, 3'd2, 4'd3, 3'd1, 32'h0000_2000, 32'hA5A5_A5A5, 1'b0);
        beat(ReleaseData, 3'd2, 4'd3, 3'd1, 32'h0000_2004, 32'h0F0F_0F0F, 1'b1);
        expectRec(mkHdr(ReleaseData, 3'd2, 4'd3, 3'd1, 32'h0000_2000), 8'd2, 32'hAAAA_AAAA, 3'b110);
        popCheck("hdrchg");

        // Truncation: 3 of 8 beats then valid low for 256 cycles
        beat(ProbeAckData, 3'd0, 4'd5, 3'd4, 32'h0000_3000, 32'h1, 1'b0);
        beat(ProbeAckData, 3'd0, 4'd5, 3'd4, 32'h0000_3000, 32'h2, 1'b0);
        beat(ProbeAckData, 3'd0, 4'd5, 3'd4, 32'h0000_3000, 32'h4, 1'b0);
        for (int i = 0; i < 255; i++) tick();
        check("trunc.busy_255", 64'(busy), 64'd1);
        check("trunc.valid_255", 64'(rec_valid), 64'd0);
        tick();
        check("trunc.busy_256", 64'(busy), 64'd0);
        check("trunc.valid_256", 64'(rec_valid), 64'd1);
        expectRec(mkHdr(ProbeAckData, 3'd0, 4'd5, 3'd4, 32'h0000_3000), 8'd3, 32'h7, 3'b001);
        popCheck("trunc");
        beat(Release, 3'd3, 4'd6, 3'd5, 32'h0000_4000, 32'h55, 1'b0);
        expectRec(mkHdr(Release, 3'd3, 4'd6, 3'd5, 32'h0000_4000), 8'd1, 32'd0, 3'b000);
        popCheck("post_trunc");

        // Overflow: six single-beat messages with readout stalled
        for (int i = 0; i < 6; i++) begin
            beat(ProbeAck, 3'd0, 4'd0, 3'(i), 32'h100 + 32'(i), 32'h0, 1'b0);
            if (i < 4) expectRec(mkHdr(ProbeAck, 3'd0, 4'd0, 3'(i), 32'h100 + 32'(i)), 8'd1, 32'd0, 3'b000);
        end
        check("ovf.drop2", 64'(drop_count), 64'd2);
        check("ovf.valid", 64'(rec_valid), 64'd1);
        // Push coincident with pop while full
        cmpHead("coinc");
        rec_ready = 1'b1;
        beat(ProbeAck, 3'd0, 4'd0, 3'd6, 32'h0000_0106, 32'h0, 1'b0);
        rec_ready = 1'b0;
        expectRec(mkHdr(ProbeAck, 3'd0, 4'd0, 3'd6, 32'h0000_0106), 8'd1, 32'd0, 3'b000);
        check("coinc.drop", 64'(drop_count), 64'd2);
        for (int i = 0; i < 4; i++) popCheck("order");
        check("order.empty", 64'(rec_valid), 64'd0);

        // Sustained overflow saturates the drop counter
        for (int i = 0; i < 264; i++) begin
            setBeat(ProbeAck, 3'd0, 4'd0, 3'd1, 32'h200 + 32'(i), 32'h0, 1'b0);
            tick();
        end
        c_valid = 1'b0;
        check("sat.drop", 64'(drop_count), 64'd255);
        check("sat.full_valid", 64'(rec_valid), 64'd1);

        // Asynchronous reset mid-burst
        beat(ReleaseData, 3'd0, 4'd5, 3'd0, 32'h0000_5000, 32'h9, 1'b0);
        beat(ReleaseData, 3'd0, 4'd5, 3'd0, 32'h0000_5000, 32'hA, 1'b0);
        check("rstmid.busy_before", 64'(busy), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmid.valid", 64'(rec_valid), 64'd0);
        check("rstmid.busy", 64'(busy), 64'd0);
        check("rstmid.drop", 64'(drop_count), 64'd0);
        check("rstmid.header", 64'(rec_header), 64'd0);
        expQ.delete();
        #5;
        reset_n = 1'b1;
        tick();
        beat(ProbeAck, 3'd1, 4'd6, 3'd2, 32'h0000_6000, 32'h0, 1'b0);
        expectRec(mkHdr(ProbeAck, 3'd1, 4'd6, 3'd2, 32'h0000_6000), 8'd1, 32'd0, 3'b000);
        popCheck("post_rst");
        tick();
        tick();
        check("post_rst.single", 64'(rec_valid), 64'd0);
        check("post_rst.queue_empty", 64'(expQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
